exe_status_stage: RTL and testbench

EX/MEM boundary stage that sits directly downstream of the ALU. It registers the ALU result and memory/write-back control into the memory stage, and owns the architectural NZCV status register. That register is updated from the ALU status output on S-bit instructions and feeds the ALU carry-in. It also evaluates the 4-bit condition field of the instruction in decode against the current flags. Freeze and flush inputs let the hazard unit and branch logic stall the stage or turn it into a bubble.

---
 rtl/exe_status_stage.sv | 133 +++++++++++++
 tb/tb_exe_status_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/exe_status_stage.sv
// EX/MEM boundary register, NZCV status register and condition check.
// Optional macro: STATUS_BYPASS_EN forwards the EX-stage flags to condPass.
//
// Ports:
//   clk, rst (async, active-low), freeze, flush
//   validIn, sUpdate, aluResult, statusIn, storeData, destIn
//   wbEnIn, memReadIn, memWriteIn, condCode
//   resultOut, storeDataOut, destOut, wbEnOut, memReadOut,
//   memWriteOut, validOut, statusReg, carryOut, condPass
module exe_status_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        validIn,
  input  logic        sUpdate,
  input  logic [31:0] aluResult,
  input  logic [3:0]  statusIn,
  input  logic [31:0] storeData,
  input  logic [3:0]  destIn,
  input  logic        wbEnIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [3:0]  condCode,
  output logic [31:0] resultOut,
  output logic [31:0] storeDataOut,
  output logic [3:0]  destOut,
  output logic        wbEnOut,
  output logic        memReadOut,
  output logic        memWriteOut,
  output logic        validOut,
  output logic [3:0]  statusReg,
  output logic        carryOut,
  output logic        condPass
);

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sdata;
    logic [3:0]  dest;
    logic        wb;
    logic        mrd;
    logic        mwr;
    logic        valid;
  } ex_mem_t;

  ex_mem_t    pipe_q, pipe_d;
  logic [3:0] stat_q, stat_d;
  logic       advance;
  logic       stat_we;
  logic [3:0] flags;
  logic       fn, fz, fc, fv;

  assign advance = !freeze && !flush;
  assign stat_we = advance && validIn && sUpdate;

  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (!freeze) begin
      pipe_d.result = aluResult;
      pipe_d.sdata  = storeData;
      pipe_d.dest   = destIn;
      // a bubble must never write a register or memory
      pipe_d.wb     = wbEnIn && validIn;
      pipe_d.mrd    = memReadIn && validIn;
      pipe_d.mwr    = memWriteIn && validIn;
      pipe_d.valid  = validIn;
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (stat_we) stat_d = statusIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
      stat_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      stat_q <= stat_d;
    end
  end

  assign resultOut    = pipe_q.result;
  assign storeDataOut = pipe_q.sdata;
  assign destOut      = pipe_q.dest;
  assign wbEnOut      = pipe_q.wb;
  assign memReadOut   = pipe_q.mrd;
  assign memWriteOut  = pipe_q.mwr;
  assign validOut     = pipe_q.valid;
  assign statusReg    = stat_q;
  // carry-in for ADC/SBC comes only from committed flags
  assign carryOut     = stat_q[1];

`ifdef STATUS_BYPASS_EN
  // an S instruction in EX is visible to ID in the same cycle
  assign flags = stat_we ? statusIn : stat_q;
`else
  assign flags = stat_q;
`endif

  assign fn = flags[3];
  assign fz = flags[2];
  assign fc = flags[1];
  assign fv = flags[0];

  always_comb begin
    condPass = 1'b0;
    unique case (condCode)
      4'b0000: condPass = fz;
      4'b0001: condPass = !fz;
      4'b0010: condPass = fc;
      4'b0011: condPass = !fc;
      4'b0100: condPass = fn;
      4'b0101: condPass = !fn;
      4'b0110: condPass = fv;
      4'b0111: condPass = !fv;
      4'b1000: condPass = fc && !fz;
      4'b1001: condPass = !fc || fz;
      4'b1010: condPass = (fn == fv);
      4'b1011: condPass = (fn != fv);
      4'b1100: condPass = !fz && (fn == fv);
      4'b1101: condPass = fz || (fn != fv);
      4'b1110: condPass = 1'b1;
      4'b1111: condPass = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exe_status_stage.sv
// Directed self-checking bench for exe_status_stage.
// Handles both the default and STATUS_BYPASS_EN builds.
module tb_exe_status_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush, validIn, sUpdate;
  logic [31:0] aluResult, storeData;
  logic [3:0]  statusIn, destIn, condCode;
  logic        wbEnIn, memReadIn, memWriteIn;
  logic [31:0] resultOut, storeDataOut;
  logic [3:0]  destOut, statusReg;
  logic        wbEnOut, memReadOut, memWriteOut, validOut;
  logic        carryOut, condPass;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_status_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .validIn(validIn), .sUpdate(sUpdate), .aluResult(aluResult),
    .statusIn(statusIn), .storeData(storeData), .destIn(destIn),
    .wbEnIn(wbEnIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .condCode(condCode), .resultOut(resultOut),
    .storeDataOut(storeDataOut), .destOut(destOut),
    .wbEnOut(wbEnOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .validOut(validOut),
    .statusReg(statusReg), .carryOut(carryOut), .condPass(condPass)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cond(input string tag, input logic [3:0] cc,
                      input logic exp);
    condCode = cc;
    #1;
    check(tag, {31'b0, condPass}, {31'b0, exp});
  endtask

  initial begin
    rst = 1'b0; freeze = 0; flush = 0; validIn = 0; sUpdate = 0;
    aluResult = 0; storeData = 0; statusIn = 0; destIn = 0;
    wbEnIn = 0; memReadIn = 0; memWriteIn = 0; condCode = 0;
    #12 rst = 1'b1;
    #1;
    check("rst_result", resultOut, 0);
    check("rst_status", {28'b0, statusReg}, 0);
    check("rst_valid", {31'b0, validOut}, 0);
    cond("rst_eq", 4'b0000, 1'b0);
    cond("rst_ne", 4'b0001, 1'b1);
    cond("rst_al", 4'b1110, 1'b1);

    // S instruction: Z set; also probes the bypass path before the edge
    validIn = 1; sUpdate = 1; statusIn = 4'b0100; aluResult = 0;
    destIn = 4'd5; wbEnIn = 1; storeData = 32'hAAAA_5555;
`ifdef STATUS_BYPASS_EN
    cond("byp_same_cycle", 4'b0000, 1'b1);
`else
    cond("byp_same_cycle", 4'b0000, 1'b0);
`endif
    step();
    check("s_status", {28'b0, statusReg}, 32'h4);
    check("s_result", resultOut, 0);
    check("s_dest", {28'b0, destOut}, 5);
    check("s_wb", {31'b0, wbEnOut}, 1);
    check("s_valid", {31'b0, validOut}, 1);
    check("s_sdata", storeDataOut, 32'hAAAA_5555);
    cond("s_eq", 4'b0000, 1'b1);

    // same stimulus, no S bit: flags hold
    sUpdate = 0; statusIn = 4'b0010; aluResult = 32'd123;
    step();
    check("nos_status", {28'b0, statusReg}, 32'h4);
    check("nos_result", resultOut, 32'd123);

    // carry chain
    sUpdate = 1; statusIn = 4'b0010;
    step();
    check("c_carry", {31'b0, carryOut}, 1);
    sUpdate = 0; statusIn = 4'b0000;
    step();
    check("c_carry_hold", {31'b0, carryOut}, 1);
    check("c_status", {28'b0, statusReg}, 32'h2);
    cond("hi_pass", 4'b1000, 1'b1);
    cond("ls_fail", 4'b1001, 1'b0);
    cond("rsv_fail", 4'b1111, 1'b0);
    cond("cs_pass", 4'b0010, 1'b1);

    // N=1, V=0
    sUpdate = 1; statusIn = 4'b1000;
    step();
    sUpdate = 0;
    check("n_status", {28'b0, statusReg}, 32'h8);
    cond("ge_fail", 4'b1010, 1'b0);
    cond("lt_pass", 4'b1011, 1'b1);
    cond("gt_fail", 4'b1100, 1'b0);
    cond("le_pass", 4'b1101, 1'b1);
    cond("mi_pass", 4'b0100, 1'b1);
    cond("rsv_fail2", 4'b1111, 1'b0);

    // freeze three cycles with changing inputs
    aluResult = 32'd900; destIn = 4'd9;
    step();
    check("pre_frz_result", resultOut, 32'd900);
    freeze = 1; sUpdate = 1;
    for (int i = 0; i < 3; i++) begin
      aluResult = 32'd1000 + i; statusIn = 4'b0001;
      destIn = 4'(i); validIn = i[0];
      step();
      check("frz_result", resultOut, 32'd900);
      check("frz_dest", {28'b0, destOut}, 9);
      check("frz_status", {28'b0, statusReg}, 32'h8);
    end

    // next advancing edge captures the present inputs
    freeze = 0; sUpdate = 0; validIn = 1;
    aluResult = 32'd77; memWriteIn = 1; wbEnIn = 0;
    step();
    check("adv_result", resultOut, 32'd77);
    check("adv_memw", {31'b0, memWriteOut}, 1);

    // bubble: controls masked, flags untouched
    validIn = 0; wbEnIn = 1; memReadIn = 1; memWriteIn = 1;
    sUpdate = 1; statusIn = 4'b0101; aluResult = 32'd55;
    step();
    check("bub_valid", {31'b0, validOut}, 0);
    check("bub_wb", {31'b0, wbEnOut}, 0);
    check("bub_memr", {31'b0, memReadOut}, 0);
    check("bub_status", {28'b0, statusReg}, 32'h8);
    check("bub_result", resultOut, 32'd55);

    // freeze and flush together: flush wins, flags held
    freeze = 1; flush = 1; validIn = 1; memWriteIn = 1;
    sUpdate = 1; statusIn = 4'b0110; destIn = 4'd7;
    step();
    check("ff_valid", {31'b0, validOut}, 0);
    check("ff_memw", {31'b0, memWriteOut}, 0);
    check("ff_result", resultOut, 0);
    check("ff_dest", {28'b0, destOut}, 0);
    check("ff_status", {28'b0, statusReg}, 32'h8);

    // back-to-back S instructions
    freeze = 0; flush = 0; memWriteIn = 0; memReadIn = 0;
    statusIn = 4'b0001; aluResult = 32'hDEAD_BEEF;
    step();
    check("b2b_first", {28'b0, statusReg}, 32'h1);
    statusIn = 4'b0110;
    step();
    check("b2b_last", {28'b0, statusReg}, 32'h6);
    check("b2b_carry", {31'b0, carryOut}, 1);

    // asynchronous reset mid-stream under freeze
    freeze = 1; sUpdate = 0;
    #2 rst = 1'b0;
    #1;
    check("arst_result", resultOut, 0);
    check("arst_status", {28'b0, statusReg}, 0);
    check("arst_valid", {31'b0, validOut}, 0);
    check("arst_wb", {31'b0, wbEnOut}, 0);
    check("arst_carry", {31'b0, carryOut}, 0);
    cond("arst_eq", 4'b0000, 1'b0);
    cond("arst_al", 4'b1110, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
